// File: rtl/bv4_inv_pipe.sv
// Two-stage pipelined GF(2^4) inverter in normal basis {Gamma_1, Gamma_0}.
// Zero maps to zero. A ready/valid handshake and a result counter wrap the datapath.

package bv4_pkg;
    typedef logic [3:0] bv4_t;
    typedef logic [1:0] bv2_t;
endpackage

// GF(2^2) multiplier in normal basis (W^2, W).
module bv2_mul (
    input  logic [1:0] in_x,
    input  logic [1:0] in_y,
    output logic [1:0] out_z
);
    logic shared;

    always_comb begin
        shared = (in_x[1] ^ in_x[0]) & (in_y[1] ^ in_y[0]);
        out_z  = {(in_x[1] & in_y[1]) ^ shared, (in_x[0] & in_y[0]) ^ shared};
    end
endmodule

// Theta = (G1*G0 + (G1+G0)^2 * N)^-1 over GF(2^2), with N = W^2.
module bv4_comp_theta (
    input  logic [1:0] in_g1,
    input  logic [1:0] in_g0,
    output logic [1:0] out_theta
);
    logic [1:0] sum_sq;
    logic [1:0] scaled;
    logic [1:0] prod;
    logic [1:0] denom;

    bv2_mul u_mul (
        .in_x  (in_g1),
        .in_y  (in_g0),
        .out_z (prod)
    );

    // Squaring is a bit swap in normal basis; inversion in GF(4) is squaring.
    always_comb begin
        sum_sq    = {in_g1[0] ^ in_g0[0], in_g1[1] ^ in_g0[1]};
        scaled    = {sum_sq[0], sum_sq[1] ^ sum_sq[0]};
        denom     = prod ^ scaled;
        out_theta = {denom[0], denom[1]};
    end
endmodule

module bv4_inv_pipe #(
    parameter int COUNT_WIDTH = 8
) (
    input  logic                    in_clock,
    input  logic                    in_reset,
    input  logic                    in_valid,
    output logic                    out_ready,
    input  bv4_pkg::bv4_t           in_a,
    output logic                    out_valid,
    input  logic                    in_ready,
    output bv4_pkg::bv4_t           out_b,
    output logic [COUNT_WIDTH-1:0]  out_count
);
    import bv4_pkg::*;

    logic                   s1_valid_q, s1_valid_d;
    bv2_t                   g1_q, g1_d;
    bv2_t                   g0_q, g0_d;
    bv2_t                   theta_q, theta_d;
    logic                   s2_valid_q, s2_valid_d;
    bv4_t                   b_q, b_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    bv2_t theta_in;
    bv2_t prod_hi;
    bv2_t prod_lo;
    logic s2_en;
    logic s1_en;
    logic in_fire;
    logic out_fire;

    bv4_comp_theta u_theta (
        .in_g1     (in_a[3:2]),
        .in_g0     (in_a[1:0]),
        .out_theta (theta_in)
    );

    bv2_mul u_mul_hi (
        .in_x  (theta_q),
        .in_y  (g0_q),
        .out_z (prod_hi)
    );

    bv2_mul u_mul_lo (
        .in_x  (theta_q),
        .in_y  (g1_q),
        .out_z (prod_lo)
    );

    always_comb begin
        s2_en    = !s2_valid_q || in_ready;
        s1_en    = s2_en || !s1_valid_q;
        in_fire  = in_valid && s1_en;
        out_fire = s2_valid_q && in_ready;

        s1_valid_d = s1_valid_q;
        g1_d       = g1_q;
        g0_d       = g0_q;
        theta_d    = theta_q;
        s2_valid_d = s2_valid_q;
        b_d        = b_q;
        count_d    = count_q;

        if (s1_en) begin
            s1_valid_d = in_fire;
        end
        if (in_fire) begin
            g1_d    = in_a[3:2];
            g0_d    = in_a[1:0];
            theta_d = theta_in;
        end
        if (s2_en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                b_d = {prod_hi, prod_lo};
            end
        end
        if (out_fire) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            s1_valid_q <= 1'b0;
            g1_q       <= '0;
            g0_q       <= '0;
            theta_q    <= '0;
            s2_valid_q <= 1'b0;
            b_q        <= '0;
            count_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            g1_q       <= g1_d;
            g0_q       <= g0_d;
            theta_q    <= theta_d;
            s2_valid_q <= s2_valid_d;
            b_q        <= b_d;
            count_q    <= count_d;
        end
    end

    assign out_ready = s1_en;
    assign out_valid = s2_valid_q;
    assign out_b     = b_q;
    assign out_count = count_q;
endmodule
